// File: rtl/tube_tx_arbiter.sv
// tube_tx_arbiter: round-robin, message-granular arbiter that shares one
// serial line (8 data bits, LSB first, STOP_BITS stop bits, one bit per
// CLK) between NUM_REQ character sources.
//
// Handshake: a requester raises REQ[i] with DATA/LAST stable and holds it
// until it sees ACK[i] (a one-cycle registered pulse); it may change
// REQ/DATA/LAST from the cycle after ACK. The arbiter samples requests only
// while the FSM is IDLE.
//
// Optional feature: define TUBE_TX_ARBITER_LOCK_TIMEOUT_EN to release a
// message lock whose owner stays silent for LOCK_TIMEOUT idle cycles.
module tube_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int STOP_BITS    = 1,
    parameter int LOCK_TIMEOUT = 256
) (
    input  logic                   CLK,
    input  logic                   RESETn,
    input  logic [NUM_REQ-1:0]     REQ,
    input  logic [8*NUM_REQ-1:0]   DATA,
    input  logic [NUM_REQ-1:0]     LAST,
    output logic [NUM_REQ-1:0]     ACK,
    output logic [NUM_REQ-1:0]     GRANT,
    output logic                   TXD,
    output logic                   BUSY,
    output logic                   TIMEOUT
);

    localparam int              PW           = $clog2(NUM_REQ);
    localparam logic [2:0]      LP_STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [PW-1:0]   LP_PTR_RST   = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic [2:0]         r_bit_cnt, w_bit_cnt_nxt;
    logic               r_lock, w_lock_nxt;
    logic [PW-1:0]      r_owner, w_owner_nxt;
    logic [PW-1:0]      r_ptr, w_ptr_nxt;
    logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic               r_txd, w_txd_nxt;
    logic               r_busy, w_busy_nxt;

    logic               w_found;
    logic [PW-1:0]      w_winner;
    logic               w_accept;
    logic               w_to_fire;

    // Pick the winner: the lock owner only, or the first REQ above ptr with wrap.
    always_comb begin
        logic [PW-1:0] v_idx;
        v_idx    = r_ptr;
        w_found  = 1'b0;
        w_winner = r_ptr;
        if (r_lock) begin
            w_found  = REQ[r_owner];
            w_winner = r_owner;
        end else begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                v_idx = PW'((int'(r_ptr) + i) % NUM_REQ);
                if (!w_found && REQ[v_idx]) begin
                    w_found  = 1'b1;
                    w_winner = v_idx;
                end
            end
        end
    end

    // A timeout release and an accept never coincide: the owner is silent.
    assign w_accept = (r_state == S_IDLE) && w_found && !w_to_fire;

    // Next-state logic for the framing FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_START;
            S_START: w_state_nxt = S_DATA;
            S_DATA:  if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
            S_STOP:  if (r_bit_cnt == LP_STOP_LAST) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the datapath and of every registered output.
    always_comb begin
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = 3'd0;
        w_lock_nxt    = r_lock;
        w_owner_nxt   = r_owner;
        w_ptr_nxt     = r_ptr;
        w_ack_nxt     = '0;
        w_txd_nxt     = 1'b1;
        w_grant_nxt   = '0;

        // One counter serves both the data bits and the stop bits.
        if ((w_state_nxt == r_state) && ((r_state == S_DATA) || (r_state == S_STOP)))
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;

        if (w_accept) begin
            w_shift_nxt         = DATA[8*w_winner +: 8];
            w_ack_nxt[w_winner] = 1'b1;
            if (LAST[w_winner]) begin
                w_lock_nxt = 1'b0;
                w_ptr_nxt  = w_winner;
            end else begin
                w_lock_nxt  = 1'b1;
                w_owner_nxt = w_winner;
            end
        end else if (w_to_fire) begin
            w_lock_nxt = 1'b0;
            w_ptr_nxt  = r_owner;
        end

        // TXD is registered alongside the state it belongs to.
        if (w_state_nxt == S_DATA) begin
            w_txd_nxt   = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[7:1]};
        end else if (w_state_nxt == S_START) begin
            w_txd_nxt = 1'b0;
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
        if (w_lock_nxt)
            w_grant_nxt[w_owner_nxt] = 1'b1;
    end

    // State register plus all registered outputs, synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_lock    <= 1'b0;
            r_owner   <= '0;
            r_ptr     <= LP_PTR_RST;
            r_ack     <= '0;
            r_grant   <= '0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_lock    <= w_lock_nxt;
            r_owner   <= w_owner_nxt;
            r_ptr     <= w_ptr_nxt;
            r_ack     <= w_ack_nxt;
            r_grant   <= w_grant_nxt;
            r_txd     <= w_txd_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

`ifdef TUBE_TX_ARBITER_LOCK_TIMEOUT_EN
    localparam logic [15:0] LP_TO_LAST = 16'(LOCK_TIMEOUT - 1);

    logic [15:0] r_to_cnt;
    logic        r_timeout;
    logic        w_to_wait;

    // Counting only while a locked owner leaves the line idle.
    assign w_to_wait = r_lock && (r_state == S_IDLE) && !REQ[r_owner];
    assign w_to_fire = w_to_wait && (r_to_cnt == LP_TO_LAST);

    // Abandoned-lock counter and its one-cycle release pulse.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_fire;
            if (w_accept || !r_lock || w_to_fire)
                r_to_cnt <= '0;
            else if (w_to_wait)
                r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    assign TIMEOUT = r_timeout;
`else
    assign w_to_fire = 1'b0;
    assign TIMEOUT   = 1'b0;
`endif

    assign ACK   = r_ack;
    assign GRANT = r_grant;
    assign TXD   = r_txd;
    assign BUSY  = r_busy;

endmodule

// File: tb/tb_tube_tx_arbiter.sv
// Bench for tube_tx_arbiter: directed requester drivers, a serial-line
// monitor that decodes frames and checks them against an expected queue,
// plus a second instance built with two stop bits.
module tb_tube_tx_arbiter;

  localparam int SB = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  last;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        txd;
  logic        busy;
  logic        timeout;

  logic [3:0]  req2;
  logic [31:0] data2;
  logic [3:0]  last2;
  logic [3:0]  ack2;
  logic [3:0]  grant2;
  logic        txd2;
  logic        busy2;
  logic        timeout2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // {last, id[2:0], data[7:0]} in the order frames must appear on the line
  logic [11:0] exp_q[$];
  int          ack_cyc[$];

  tube_tx_arbiter #(.NUM_REQ(4), .STOP_BITS(1), .LOCK_TIMEOUT(16)) u_dut (
    .CLK(clk), .RESETn(rst_n), .REQ(req), .DATA(data), .LAST(last),
    .ACK(ack), .GRANT(grant), .TXD(txd), .BUSY(busy), .TIMEOUT(timeout)
  );

  tube_tx_arbiter #(.NUM_REQ(4), .STOP_BITS(2), .LOCK_TIMEOUT(16)) u_dut2 (
    .CLK(clk), .RESETn(rst_n), .REQ(req2), .DATA(data2), .LAST(last2),
    .ACK(ack2), .GRANT(grant2), .TXD(txd2), .BUSY(busy2), .TIMEOUT(timeout2)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [2:0] id);
    logic [3:0] one;
    one = 4'b0001;
    return one << id;
  endfunction

  function automatic logic [11:0] ent(input logic l, input logic [2:0] id, input logic [7:0] d);
    return {l, id, d};
  endfunction

  // ---------------- driver ----------------
  task automatic send(input int id, input logic [7:0] d, input logic l);
    bit got;
    got = 1'b0;
    req[id]        = 1'b1;
    data[8*id +: 8] = d;
    last[id]       = l;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (ack[id]) begin
        got = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL ack_timeout: requester %0d got no ACK, required one", id);
    end
    req[id] = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !rx_active) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_drain: %0d frames outstanding, required 0", name, exp_q.size());
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        rx_active = 1'b0;
  int          rx_cnt;
  logic [7:0]  rx_byte;
  logic [3:0]  rx_grant;
  logic [11:0] cur;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (txd === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        rx_grant  = 4'b0000;
        ack_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame: start bit with ACK=%b, required no frame", ack);
        end else begin
          cur      = exp_q[0];
          rx_grant = cur[11] ? 4'b0000 : onehot(cur[10:8]);
          check("ack_with_start", 32'(ack), 32'(onehot(cur[10:8])));
          check("grant_at_start", 32'(grant), 32'(rx_grant));
          check("busy_at_start", 32'(busy), 32'd1);
        end
      end else begin
        check("idle_ack", 32'(ack), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
`ifndef TUBE_TX_ARBITER_LOCK_TIMEOUT_EN
        check("idle_timeout", 32'(timeout), 32'd0);
`endif
      end
    end else begin
      check("ack_in_frame", 32'(ack), 32'd0);
      check("grant_in_frame", 32'(grant), 32'(rx_grant));
      check("busy_in_frame", 32'(busy), 32'd1);
      if (rx_cnt < 8) rx_byte[rx_cnt] = txd;
      else check("stop_bit", 32'(txd), 32'd1);
      rx_cnt++;
      if (rx_cnt == 8 + SB) begin
        rx_active = 1'b0;
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          check("frame_data", 32'(rx_byte), 32'(cur[7:0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] seq;
    logic [9:0] seq_exp;
    int         base;
    logic       a_tr[40];
    logic       t_tr[40];
    int         ak[$];

    rst_n = 1'b0;
    req   = '0; data  = '0; last  = '0;
    req2  = '0; data2 = '0; last2 = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // single byte 'A' from requester 0, raw line sequence checked too
    exp_q.push_back(ent(1'b1, 3'd0, 8'h41));
    send(0, 8'h41, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seq[i] = txd;
    end
    seq_exp = 10'b1010000010;
    check("single_txd_seq", 32'(seq), 32'(seq_exp));
    drain("single");

    // contention: 1 then 2 then 1 again, ACKs 11 cycles apart
    base = ack_cyc.size();
    exp_q.push_back(ent(1'b1, 3'd1, 8'h61));
    exp_q.push_back(ent(1'b1, 3'd2, 8'h62));
    exp_q.push_back(ent(1'b1, 3'd1, 8'h63));
    fork
      begin
        send(1, 8'h61, 1'b1);
        send(1, 8'h63, 1'b1);
      end
      send(2, 8'h62, 1'b1);
    join
    drain("contention");
    check("contention_frames", 32'(ack_cyc.size() - base), 32'd3);
    if (ack_cyc.size() - base == 3) begin
      check("contention_gap1", 32'(ack_cyc[base+1] - ack_cyc[base]), 32'd11);
      check("contention_gap2", 32'(ack_cyc[base+2] - ack_cyc[base+1]), 32'd11);
    end

    // message lock: requester 3 sends "OK\n" while requester 0 waits
    exp_q.push_back(ent(1'b0, 3'd3, 8'h4F));
    exp_q.push_back(ent(1'b0, 3'd3, 8'h4B));
    exp_q.push_back(ent(1'b1, 3'd3, 8'h0A));
    exp_q.push_back(ent(1'b1, 3'd0, 8'h5A));
    fork
      begin
        send(3, 8'h4F, 1'b0);
        send(3, 8'h4B, 1'b0);
        send(3, 8'h0A, 1'b1);
      end
      send(0, 8'h5A, 1'b1);
    join
    drain("lock");

    // reset during data bit 4 of a locked byte from requester 1
    exp_q.push_back(ent(1'b0, 3'd1, 8'h0F));
    send(1, 8'h0F, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("pre_reset_bit4", 32'(txd), 32'd0);
    check("pre_reset_grant", 32'(grant), 32'b0010);
    @(negedge clk);
    check("midreset_txd", 32'(txd), 32'd1);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_grant", 32'(grant), 32'd0);
    check("midreset_ack", 32'(ack), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(ent(1'b1, 3'd0, 8'h72));
    exp_q.push_back(ent(1'b1, 3'd1, 8'h73));
    fork
      send(0, 8'h72, 1'b1);
      send(1, 8'h73, 1'b1);
    join
    drain("post_reset");

`ifdef TUBE_TX_ARBITER_LOCK_TIMEOUT_EN
    // abandoned lock by owner 2 is released after 16 idle cycles
    exp_q.push_back(ent(1'b0, 3'd2, 8'h31));
    exp_q.push_back(ent(1'b1, 3'd3, 8'h32));
    fork
      begin
        send(2, 8'h31, 1'b0);
        for (int j = 0; j < 28; j++) begin
          @(negedge clk);
          check("timeout_pulse", 32'(timeout), (j == 26) ? 32'd1 : 32'd0);
          if (j == 27) check("timeout_next_ack", 32'(ack), 32'b1000);
        end
      end
      send(3, 8'h32, 1'b1);
    join
    drain("timeout");
`endif

    // two stop bits: continuous requester, ACKs 12 cycles apart
    req2[0]     = 1'b1;
    data2[7:0]  = 8'h55;
    last2[0]    = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a_tr[i] = ack2[0];
      t_tr[i] = txd2;
    end
    req2 = '0;
    for (int i = 0; i < 40; i++) if (a_tr[i]) ak.push_back(i);
    check("sb2_ack_count", 32'(ak.size()), 32'd4);
    for (int n = 1; n < ak.size(); n++) begin
      check("sb2_ack_gap", 32'(ak[n] - ak[n-1]), 32'd12);
      if (ak[n] >= 4) begin
        check("sb2_start", 32'(t_tr[ak[n]]), 32'd0);
        check("sb2_high_run", 32'({t_tr[ak[n]-3], t_tr[ak[n]-2], t_tr[ak[n]-1]}), 32'b111);
        check("sb2_bit7", 32'(t_tr[ak[n]-4]), 32'd0);
      end
    end

    drain("final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
